// File: rtl/udp_echo_pkg.sv
// Shared types and sizing constants for the UDP AXI-Stream echo responder.
package udp_echo_pkg;
    localparam int DEF_DATA_WIDTH    = 512;
    localparam int DEF_KEEP_WIDTH    = DEF_DATA_WIDTH / 8;
    localparam int DEF_BUF_DEPTH     = 64;
    localparam int DEF_MAX_PKT_BEATS = 32;
    localparam int COUNT_W           = 32;

    // One extra bit beyond the address distinguishes full from empty.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int PTR_W = ptr_w(DEF_BUF_DEPTH);

    typedef struct packed {
        logic                      last;
        logic [DEF_KEEP_WIDTH-1:0] keep;
        logic [DEF_DATA_WIDTH-1:0] data;
    } beat_t;

    typedef enum logic [1:0] {RX_WAIT_SOP, RX_ACCEPT, RX_DISCARD} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_GAP} tx_state_t;
endpackage

// File: rtl/axis_beat_ram.sv
// Simple dual-port beat store: one write port, one registered read port.
module axis_beat_ram #(
    parameter int WIDTH = 577,
    parameter int DEPTH = 64
) (
    input  logic                     CLK,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/udp_axis_echo_responder.sv
// Store-and-forward echo responder: buffers each RX packet whole, drops bad
// ones by rolling back the speculative write pointer, replays the rest on TX.
//
// state       | meaning
// RX_WAIT_SOP | between packets; first beat decides accept or discard
// RX_ACCEPT   | writing beats speculatively into the buffer
// RX_DISCARD  | ignoring beats until the dropped packet's tlast
// TX_IDLE     | waiting for a committed packet; issues the first read
// TX_SEND     | presenting beats, advancing on each handshake
// TX_GAP      | idle cycles after a transmitted tlast
module udp_axis_echo_responder
    import udp_echo_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int KEEP_WIDTH    = DEF_KEEP_WIDTH,
    parameter int BUF_DEPTH     = DEF_BUF_DEPTH,
    parameter int MAX_PKT_BEATS = DEF_MAX_PKT_BEATS
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  enable,
    input  logic [15:0]           pkt_gap,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tuser,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    output logic [COUNT_W-1:0]    rx_pkt_count,
    output logic [COUNT_W-1:0]    tx_pkt_count,
    output logic [COUNT_W-1:0]    drop_pkt_count
);
    localparam int AW  = $clog2(BUF_DEPTH);
    localparam int PW  = ptr_w(BUF_DEPTH);
    localparam int BCW = $clog2(MAX_PKT_BEATS + 1);
    localparam logic [PW-1:0]  PTR_ONE   = PW'(1);
    localparam logic [PW-1:0]  PTR_FULL  = PW'(BUF_DEPTH);
    localparam logic [BCW-1:0] BEATS_MAX = BCW'(MAX_PKT_BEATS);

    rx_state_t      rx_state, rx_next;
    tx_state_t      tx_state, tx_next;
    logic [PW-1:0]  wr_spec, wr_commit, rd, pending;
    logic [BCW-1:0] beat_cnt;
    logic [15:0]    gap_cnt;
    logic           rx_ready, rx_beat, full;
    logic           wr_en, rollback, commit, drop;
    logic           rd_en, tx_done;
    logic [AW-1:0]  rd_addr;
    beat_t          wr_beat, rd_beat;

    assign s_axis_tready = rx_ready;
    assign rx_beat       = s_axis_tvalid && rx_ready;
    assign full          = (wr_spec - rd) == PTR_FULL;
    assign wr_beat       = '{last: s_axis_tlast, keep: s_axis_tkeep, data: s_axis_tdata};

    axis_beat_ram #(.WIDTH($bits(beat_t)), .DEPTH(BUF_DEPTH)) u_ram (
        .CLK   (CLK),
        .we    (wr_en),
        .waddr (wr_spec[AW-1:0]),
        .wdata (wr_beat),
        .re    (rd_en),
        .raddr (rd_addr),
        .rdata (rd_beat)
    );

    always_comb begin
        rx_next  = rx_state;
        wr_en    = 1'b0;
        rollback = 1'b0;
        commit   = 1'b0;
        drop     = 1'b0;
        case (rx_state)
            RX_WAIT_SOP, RX_ACCEPT: begin
                if (rx_beat) begin
                    if ((rx_state == RX_WAIT_SOP && !enable) || full ||
                        (rx_state == RX_ACCEPT && beat_cnt == BEATS_MAX)) begin
                        // An overflow beat that is also tlast closes the drop here.
                        rollback = 1'b1;
                        drop     = s_axis_tlast;
                        rx_next  = s_axis_tlast ? RX_WAIT_SOP : RX_DISCARD;
                    end else begin
                        wr_en = 1'b1;
                        if (s_axis_tlast) begin
                            commit   = !s_axis_tuser;
                            rollback = s_axis_tuser;
                            drop     = s_axis_tuser;
                            rx_next  = RX_WAIT_SOP;
                        end else begin
                            rx_next = RX_ACCEPT;
                        end
                    end
                end
            end
            RX_DISCARD: begin
                if (rx_beat && s_axis_tlast) begin
                    drop    = 1'b1;
                    rx_next = RX_WAIT_SOP;
                end
            end
            default: rx_next = RX_WAIT_SOP;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rx_state       <= RX_WAIT_SOP;
            rx_ready       <= 1'b0;
            wr_spec        <= '0;
            wr_commit      <= '0;
            beat_cnt       <= '0;
            rx_pkt_count   <= '0;
            drop_pkt_count <= '0;
        end else begin
            rx_state <= rx_next;
            rx_ready <= 1'b1;
            if (rollback)   wr_spec <= wr_commit;
            else if (wr_en) wr_spec <= wr_spec + PTR_ONE;
            if (commit)     wr_commit <= wr_spec + PTR_ONE;
            if (wr_en)      beat_cnt <= (rx_state == RX_WAIT_SOP) ? BCW'(1) : beat_cnt + BCW'(1);
            if (commit)     rx_pkt_count <= rx_pkt_count + COUNT_W'(1);
            if (drop)       drop_pkt_count <= drop_pkt_count + COUNT_W'(1);
        end
    end

    // The RAM output register holds the presented beat; reads only advance on handshake.
    always_comb begin
        tx_next = tx_state;
        rd_en   = 1'b0;
        rd_addr = rd[AW-1:0];
        tx_done = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (pending != '0) begin
                    rd_en   = 1'b1;
                    tx_next = TX_SEND;
                end
            end
            TX_SEND: begin
                if (m_axis_tready) begin
                    if (rd_beat.last) begin
                        tx_done = 1'b1;
                        tx_next = (pkt_gap != 16'd0) ? TX_GAP : TX_IDLE;
                    end else begin
                        rd_en   = 1'b1;
                        rd_addr = rd[AW-1:0] + AW'(1);
                    end
                end
            end
            TX_GAP: begin
                if (gap_cnt == 16'd1) tx_next = TX_IDLE;
            end
            default: tx_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tx_state     <= TX_IDLE;
            rd           <= '0;
            pending      <= '0;
            gap_cnt      <= '0;
            tx_pkt_count <= '0;
        end else begin
            tx_state <= tx_next;
            if (tx_state == TX_SEND && m_axis_tready) rd <= rd + PTR_ONE;
            pending <= pending + PW'(commit) - PW'(tx_done);
            if (tx_done)                 gap_cnt <= pkt_gap;
            else if (tx_state == TX_GAP) gap_cnt <= gap_cnt - 16'd1;
            if (tx_done) tx_pkt_count <= tx_pkt_count + COUNT_W'(1);
        end
    end

    assign m_axis_tvalid = (tx_state == TX_SEND);
    assign m_axis_tdata  = m_axis_tvalid ? rd_beat.data : '0;
    assign m_axis_tkeep  = m_axis_tvalid ? rd_beat.keep : '0;
    assign m_axis_tlast  = m_axis_tvalid && rd_beat.last;
    assign m_axis_tuser  = 1'b0;
endmodule

// File: doc/udp_axis_echo_responder.md
Name: udp_axis_echo_responder

Overview:
Remote-end responder for UDP/CMAC performance traffic: accepts 512-bit AXI-Stream packets from the CMAC RX path, buffers each whole packet, and retransmits it unchanged on the CMAC TX path. It is the far-side counterpart of the perf monitor's generator/checker pair and closes the loop for round-trip throughput tests. Store-and-forward with rollback drops errored, oversize and overflowing packets; drop and packet counters are exported for ILA probing.

Parameters:
DATA_WIDTH, 512, AXIS tdata width
KEEP_WIDTH, 64, AXIS tkeep width (DATA_WIDTH/8)
BUF_DEPTH, 64, beat buffer depth; power of 2, >= MAX_PKT_BEATS
MAX_PKT_BEATS, 32, largest accepted packet in beats

Ports:
CLK  in  1  clock
RST_N  in  1  asynchronous active-low reset
enable  in  1  1 = accept new packets; sampled on first beat of each packet
pkt_gap  in  16  idle cycles inserted after each transmitted tlast
s_axis_tvalid  in  1  RX beat valid
s_axis_tready  out  1  RX ready
s_axis_tdata  in  DATA_WIDTH  RX data
s_axis_tkeep  in  KEEP_WIDTH  RX byte enables
s_axis_tlast  in  1  RX end of packet
s_axis_tuser  in  1  RX error flag, meaningful on tlast beat
m_axis_tvalid  out  1  TX beat valid
m_axis_tready  in  1  TX ready
m_axis_tdata  out  DATA_WIDTH  TX data
m_axis_tkeep  out  KEEP_WIDTH  TX byte enables
m_axis_tlast  out  1  TX end of packet
m_axis_tuser  out  1  always 0
rx_pkt_count  out  32  packets committed
tx_pkt_count  out  32  packets fully sent
drop_pkt_count  out  32  packets discarded

Behaviour:
- Reset: s_axis_tready=0 while RST_N low, 1 from first cycle after release, thereafter constant 1 (CMAC RX cannot be backpressured). All m_axis_* outputs 0; counters 0; pointers 0; TX FSM IDLE.
- Buffer: circular beat RAM {tdata,tkeep,tlast}; pointers log2(BUF_DEPTH)+1 bits: wr_spec, wr_commit, rd. Full when wr_spec-rd == BUF_DEPTH.
- RX FSM: WAIT_SOP, ACCEPT, DISCARD.
  - WAIT_SOP: on a beat, if enable=0 or buffer full -> DISCARD, else write, wr_spec++, ACCEPT. A single-beat packet is handled as the tlast rules below.
  - ACCEPT: each beat written, wr_spec++. Any beat arriving when full, or beat count exceeding MAX_PKT_BEATS -> wr_spec<=wr_commit, DISCARD.
  - tlast accepted in ACCEPT: tuser=0 -> wr_commit<=wr_spec+1, pending_pkts++, rx_pkt_count++; tuser=1 -> wr_spec<=wr_commit, drop_pkt_count++. Return to WAIT_SOP.
  - DISCARD: beats ignored; on tlast drop_pkt_count++ once, return to WAIT_SOP.
- TX FSM: IDLE, SEND, GAP.
  - IDLE -> SEND when pending_pkts>0; read first beat.
  - SEND: m_axis_tvalid held with stable data until tready. On handshake rd++; on tlast handshake pending_pkts--, tx_pkt_count++, go to GAP if pkt_gap>0 else IDLE.
  - GAP: count pkt_gap cycles, then IDLE.
- Latency: empty buffer, pkt_gap=0, m_axis_tready=1: m_axis_tvalid rises exactly 2 cycles after the input tlast handshake. Back-to-back committed packets stream with 1 idle cycle between tlast and next first beat.
- Simultaneous commit and TX tlast: pending_pkts unchanged, both counters increment.
- Counters wrap 2^32-1 -> 0.
- enable falling mid-packet has no effect on that packet.
- Reset mid-operation discards all buffered data immediately.

Decomposition:
- Package udp_echo_pkg: beat struct {data,keep,last}, RX/TX state enums, PTR_W=$clog2(BUF_DEPTH)+1, COUNT_W=32.
- Sub-module axis_beat_ram: simple dual-port RAM, 1-cycle registered read, no reset on storage.

Test Plan:
- 3-beat packet, tuser=0, tready=1, gap=0 -> identical 3 beats out; tvalid rises 2 cycles after input tlast; rx/tx_pkt_count=1.
- 2-beat packet with tuser=1 on tlast, then 1-beat good packet -> only the good beat is output; drop_pkt_count=1, rx_pkt_count=1.
- 40-beat packet (MAX_PKT_BEATS=32) -> nothing output, drop_pkt_count=1; next 4-beat packet echoes correctly.
- Hold m_axis_tready=0, send 3×32-beat packets (BUF_DEPTH=64) -> 2 committed, third dropped; release ready -> exactly 64 beats out, tx_pkt_count=2.
- pkt_gap=5, two 1-beat packets -> second tvalid no earlier than 6 cycles after first tlast handshake.
- enable=0 for one packet, then enable=1; assert RST_N low mid-transmission -> first packet dropped; after reset all outputs 0, tvalid=0, counters 0.
